// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS datapath ALU: operation codes and data width.
package alu_pkg;

    // Data path width
    localparam int ALU_W = 32;

    // Operation select codes driven by the ALU decoder
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RSVD = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // True for the codes that need the adder in subtract mode
    function automatic logic needs_subtract(input logic [2:0] code);
        return (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared 32-bit adder/subtractor used by ADD, SUB and SLT.
// Subtraction is done as a + ~b + 1 so one carry chain serves both modes.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             sub,
    output logic [ALU_W-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   wide_sum;

    // Conditionally invert b, add with carry-in = sub, and derive signed overflow
    always_comb begin
        b_eff    = b ^ {ALU_W{sub}};
        wide_sum = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
        sum      = wide_sum[ALU_W-1:0];
        carry    = wide_sum[ALU_W];
        // Overflow: both addends share a sign and the sum's sign differs from it
        overflow = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
    end

endmodule

// File: rtl/alu.sv
// 32-bit MIPS ALU with registered result and zero flag (one cycle latency).
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ALU_W-1:0] operand1,
    input  logic [ALU_W-1:0] operand2,
    input  logic [2:0]       ALU_control,
    output logic [ALU_W-1:0] result,
    output logic             isZero
);

    logic             sub_mode;
    logic [ALU_W-1:0] arith_sum;
    logic             carry_unused;
    logic             arith_overflow;
    logic             less_than;
    logic [ALU_W-1:0] next_result;
    logic             next_zero;

    assign sub_mode = needs_subtract(ALU_control);

    alu_addsub u_addsub (
        .a        (operand1),
        .b        (operand2),
        .sub      (sub_mode),
        .sum      (arith_sum),
        .carry    (carry_unused),
        .overflow (arith_overflow)
    );

    // Select the next result; SLT corrects the sign of A-B by its overflow
    always_comb begin
        next_result = '0;
        less_than   = arith_sum[ALU_W-1] ^ arith_overflow;
        case (ALU_control)
            ALU_AND:  next_result = operand1 & operand2;
            ALU_OR:   next_result = operand1 | operand2;
            ALU_ADD:  next_result = arith_sum;
            ALU_SUB:  next_result = arith_sum;
            ALU_SLT:  next_result = {{(ALU_W-1){1'b0}}, less_than};
            ALU_ANDN: next_result = operand1 & ~operand2;
            ALU_ORN:  next_result = operand1 | ~operand2;
            ALU_RSVD: next_result = '0;
            default:  next_result = '0;
        endcase
        next_zero = (next_result == '0);
    end

    // Output registers; synchronous reset leaves a zero result with the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            isZero <= 1'b1;
        end else begin
            result <= next_result;
            isZero <= next_zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by randomized
// operations checked against a behavioural model of the ALU operations.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  ALU_control;
    logic [31:0] result;
    logic        isZero;

    int n_assert = 0;
    int n_fail   = 0;

    alu dut (
        .clk         (clk),
        .reset       (reset),
        .operand1    (operand1),
        .operand2    (operand2),
        .ALU_control (ALU_control),
        .result      (result),
        .isZero      (isZero)
    );

    always #5 clk = ~clk;

    // Behavioural model of one operation, written from the arithmetic rules
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one set of inputs before a rising edge, then settle just after it
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic rst);
        @(negedge clk);
        operand1    = a;
        operand2    = b;
        ALU_control = op;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    // Compare both registered outputs with the expected values
    task automatic checkOutput(input string tag, input logic [31:0] exp_result,
                               input logic exp_zero);
        n_assert++;
        assert (result === exp_result) else begin
            n_fail++;
            $error("[TB] FAIL %s result: got %h expected %h", tag, result, exp_result);
        end
        n_assert++;
        assert (isZero === exp_zero) else begin
            n_fail++;
            $error("[TB] FAIL %s isZero: got %b expected %b", tag, isZero, exp_zero);
        end
    endtask

    // Step one operation through the DUT and check it against given constants
    task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [31:0] exp_result,
                               input logic exp_zero);
        applyStimulus(a, b, op, 1'b0);
        checkOutput(tag, exp_result, exp_zero);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_r;

        reset       = 1'b1;
        operand1    = 32'h0;
        operand2    = 32'h0;
        ALU_control = 3'b000;

        // Reset with non-zero inputs present; they must be ignored
        applyStimulus(32'h1234_5678, 32'h1111_1111, 3'b010, 1'b1);
        checkOutput("reset", 32'h0, 1'b1);

        // Basic operations on one operand pair
        runDirected("add_basic", 32'h0000_1010, 32'h0000_1000, 3'b010, 32'h0000_2010, 1'b0);
        runDirected("sub_basic", 32'h0000_1010, 32'h0000_1000, 3'b110, 32'h0000_0010, 1'b0);
        runDirected("and_basic", 32'h0000_1010, 32'h0000_1000, 3'b000, 32'h0000_1000, 1'b0);
        runDirected("or_basic",  32'h0000_1010, 32'h0000_1000, 3'b001, 32'h0000_1010, 1'b0);
        runDirected("slt_basic", 32'h0000_1010, 32'h0000_1000, 3'b111, 32'h0000_0000, 1'b1);

        runDirected("slt_true",  32'h0000_1010, 32'h0001_0000, 3'b111, 32'h0000_0001, 1'b0);
        runDirected("sub_equal", 32'h0000_1010, 32'h0000_1010, 3'b110, 32'h0000_0000, 1'b1);

        // Signed comparison corner cases
        runDirected("slt_neg1_1",   32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'd1, 1'b0);
        runDirected("slt_max_min",  32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'd0, 1'b1);
        runDirected("slt_min_max",  32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1, 1'b0);
        runDirected("slt_equal",    32'h8765_4321, 32'h8765_4321, 3'b111, 32'd0, 1'b1);

        // Wrap-around
        runDirected("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1);
        runDirected("sub_wrap", 32'h0000_0000, 32'h0000_0001, 3'b110, 32'hFFFF_FFFF, 1'b0);

        // Complement and reserved codes
        runDirected("andn", 32'hF0F0_F0F0, 32'h0F0F_FFFF, 3'b100, 32'hF0F0_0000, 1'b0);
        runDirected("orn",  32'hF0F0_F0F0, 32'h0F0F_FFFF, 3'b101, 32'hF0F0_F0F0, 1'b0);
        runDirected("rsvd", 32'hF0F0_F0F0, 32'h0F0F_FFFF, 3'b011, 32'h0000_0000, 1'b1);

        // Reset mid-stream clears outputs, then operation resumes
        runDirected("pre_reset", 32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0008, 1'b0);
        applyStimulus(32'h0000_0005, 32'h0000_0003, 3'b010, 1'b1);
        checkOutput("mid_reset", 32'h0, 1'b1);
        runDirected("post_reset", 32'h0000_0001, 32'h0000_0002, 3'b010, 32'h0000_0003, 1'b0);

        // Randomized back-to-back operations against the model
        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 32'h8000_0000;
                2: b = 32'h7FFF_FFFF;
                3: b = 32'($urandom_range(0, 3));
                default: ;
            endcase
            exp_r = model(a, b, op);
            applyStimulus(a, b, op, 1'b0);
            checkOutput($sformatf("rand%0d_op%0d", i, op), exp_r, exp_r == 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
